cpu_bus_arbiter: RTL and testbench
==================================

// Module: cpu_bus_arbiter
// PURPOSE
//  Registered three-master arbiter between the VexRiscv iBus/dBus, the dbgu32 debug memory port and the shared SoC bus (RAM/ROM/MMIO).
//  Replaces the combinational i/d mux and ad-hoc rsp pulses.
//  One transaction in flight; fixed priority dbg > dBus > iBus; decode errors answered locally.
// PARAMETERS
//  RD_LATENCY  1  cycles from mem_op asserted to mem_do valid (>=1)
//  ADR_HI      2  upper 2 bits at [17:16] for which bus responds: 00 RAM, 01 MMIO, 10 ROM, 11 = error
// PORTS
//  clk          in   1   system clock (8 MHz)
//  n_reset      in   1   async active-low reset
//  cpu_en       in   1   cpu_run; 0 = no new CPU grants, CPU responses held
//  icmd_valid   in   1   iBus fetch request
//  icmd_ready   out  1   iBus accept (comb, IDLE only)
//  icmd_adr     in   32  fetch address
//  irsp_valid   out  1   fetch data valid, 1-cycle pulse
//  irsp_error   out  1   fetch decode error (with irsp_valid)
//  irsp_inst    out  32  fetched word
//  dcmd_valid   in   1   dBus request
//  dcmd_ready   out  1   dBus accept (comb, IDLE only)
//  dcmd_wr      in   1   1 = write
//  dcmd_mask    in   4   byte enables for writes
//  dcmd_adr     in   32  data address
//  dcmd_data    in   32  write data
//  drsp_valid   out  1   read data valid, 1-cycle pulse (reads only)
//  drsp_error   out  1   read decode error
//  drsp_data    out  32  read word
//  dbg_mem_op   in   1   debug request, level, held until dbg_mem_rdy
//  dbg_rw       in   1   1 = read, 0 = write (all 4 bytes)
//  dbg_adr      in   32  debug address
//  dbg_do       in   32  debug write data
//  dbg_mem_rdy  out  1   debug done, 1-cycle pulse
//  dbg_di       out  32  debug read word, valid with dbg_mem_rdy
//  mem_op       out  1   bus strobe, exactly 1 cycle per transaction
//  mem_adr      out  32  bus address (registered)
//  mem_di       out  32  bus write data (registered)
//  mem_wren     out  4   bus byte write enables (0 = read)
//  mem_do       in   32  OR-bus read data
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; internal regs 0.
//  States IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE: grant first of dbg_mem_op, dcmd_valid&cpu_en, icmd_valid&cpu_en.
//   - Matching *_ready high that cycle (dbg has no ready).
//   - Latch adr/data/wren/owner into regs.
//   - icmd wren=0; dcmd wren=wr?mask:0; dbg wren=rw?0:4'hF.
//  ISSUE: mem_op=1 one cycle with latched values.
//   - Decode error (adr[17:16]==11 or adr[31:18]!=0): mem_op stays 0, data forced 0, error flag set.
//  WAIT: RD_LATENCY-1 cycles (skipped when RD_LATENCY=1); capture mem_do on last cycle.
//  RESP: pulse owner's rsp one cycle with registered data.
//   - Writes: no irsp/drsp pulse; dbg gets dbg_mem_rdy for both reads and writes.
//   - CPU owner with cpu_en=0: stay in RESP, no pulse, until cpu_en=1.
//  From RESP return to IDLE next cycle; read latency accept->rsp = RD_LATENCY+2.
//  Simultaneous dbg+dBus+iBus: dbg wins; losers keep valid, granted in later IDLEs.
//  dbg_mem_op arriving mid-CPU-transaction waits for IDLE (no preemption).
//  mem_adr/mem_di/mem_wren hold last value outside ISSUE; mem_wren forced 0 when mem_op=0.
//  n_reset low mid-transaction: immediate abort to IDLE, no response pulses.
// TESTING
//  iBus read 0x00000010, RAM word 0xDEADBEEF, RD_LATENCY=1 -> mem_op 1 cycle after accept; irsp_valid 3 cycles after accept, irsp_inst=0xDEADBEEF.
//  dBus write adr 0x00010004, mask 4'b0011, data 0x1234 -> mem_wren=0011 one cycle; no drsp_valid.
//  dbg, dBus, iBus all valid same cycle -> order dbg, dBus, iBus; each gets exactly one mem_op.
//  Read at 0x00030000 -> no mem_op; drsp_valid with drsp_error=1, drsp_data=0.
//  cpu_en dropped during ISSUE of fetch -> irsp_valid withheld; pulses 1 cycle after cpu_en=1; dbg request blocked meanwhile.
//  n_reset pulsed during WAIT (RD_LATENCY=3) -> all outputs 0 at once; next request served normally.

Source files
------------

// File: rtl/cpu_bus_arbiter.sv
// Purpose : registered arbiter granting the debug port, dBus and iBus (fixed priority
//           dbg > dBus > iBus) onto the shared SoC bus, one transaction in flight.
// Latency : accept -> response pulse = RD_LATENCY + 2 cycles; mem_op one cycle after accept.
// Backpr. : *_ready only in IDLE; CPU responses are held in RESP while cpu_en=0.
// Ports   : clk/n_reset; cpu_en; iBus icmd_*/irsp_*; dBus dcmd_*/drsp_*;
//           debug dbg_mem_op/dbg_rw/dbg_adr/dbg_do -> dbg_mem_rdy/dbg_di;
//           SoC bus mem_op/mem_adr/mem_di/mem_wren out, mem_do (OR-bus) in.
module cpu_bus_arbiter #(
  parameter int RD_LATENCY = 1,
  parameter int ADR_HI     = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        cpu_en,
  input  logic        icmd_valid,
  output logic        icmd_ready,
  input  logic [31:0] icmd_adr,
  output logic        irsp_valid,
  output logic        irsp_error,
  output logic [31:0] irsp_inst,
  input  logic        dcmd_valid,
  output logic        dcmd_ready,
  input  logic        dcmd_wr,
  input  logic [3:0]  dcmd_mask,
  input  logic [31:0] dcmd_adr,
  input  logic [31:0] dcmd_data,
  output logic        drsp_valid,
  output logic        drsp_error,
  output logic [31:0] drsp_data,
  input  logic        dbg_mem_op,
  input  logic        dbg_rw,
  input  logic [31:0] dbg_adr,
  input  logic [31:0] dbg_do,
  output logic        dbg_mem_rdy,
  output logic [31:0] dbg_di,
  output logic        mem_op,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_di,
  output logic [3:0]  mem_wren,
  input  logic [31:0] mem_do
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {OWN_I, OWN_D, OWN_DBG} owner_t;

  localparam int WAIT_CYC = RD_LATENCY - 1;
  localparam int CW       = $clog2(RD_LATENCY + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'((WAIT_CYC > 0) ? (WAIT_CYC - 1) : 0);

  // Region field all ones, or any bit above the region field, is unmapped.
  function automatic logic dec_err(input logic [31:0] a);
    return (&a[16 +: ADR_HI]) || (|a[31:16+ADR_HI]);
  endfunction

  state_t        state;
  owner_t        owner;
  logic          is_read;
  logic          err;
  logic          rdata_vld;
  logic [31:0]   rdata;
  logic [CW-1:0] wait_cnt;

  logic          dbg_req, d_req, i_req, gnt_any;
  owner_t        sel_own;
  logic [31:0]   sel_adr, sel_dat;
  logic [3:0]    sel_wren;
  logic          sel_read, sel_err;
  logic [31:0]   resp_word;

  // The debug master drops dbg_mem_op only after seeing dbg_mem_rdy, so the
  // request still visible in the cycle of its own completion pulse is stale.
  assign dbg_req = dbg_mem_op && !dbg_mem_rdy;
  assign d_req   = dcmd_valid && cpu_en;
  assign i_req   = icmd_valid && cpu_en;
  assign gnt_any = (state == S_IDLE) && (dbg_req || d_req || i_req);

  assign dcmd_ready = (state == S_IDLE) && !dbg_req && d_req;
  assign icmd_ready = (state == S_IDLE) && !dbg_req && !d_req && i_req;

  always_comb begin
    sel_own  = OWN_I;
    sel_adr  = icmd_adr;
    sel_dat  = '0;
    sel_wren = '0;
    sel_read = 1'b1;
    if (dbg_req) begin
      sel_own  = OWN_DBG;
      sel_adr  = dbg_adr;
      sel_dat  = dbg_do;
      sel_wren = dbg_rw ? 4'h0 : 4'hF;
      sel_read = dbg_rw;
    end else if (d_req) begin
      sel_own  = OWN_D;
      sel_adr  = dcmd_adr;
      sel_dat  = dcmd_data;
      sel_wren = dcmd_wr ? dcmd_mask : 4'h0;
      sel_read = !dcmd_wr;
    end
    sel_err = dec_err(sel_adr);
  end

  // mem_do is only valid on the first RESP cycle; later (held) cycles use the copy.
  always_comb begin
    resp_word = rdata;
    if (!rdata_vld) resp_word = err ? 32'h0 : mem_do;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state       <= S_IDLE;
      owner       <= OWN_I;
      is_read     <= 1'b0;
      err         <= 1'b0;
      rdata_vld   <= 1'b0;
      rdata       <= '0;
      wait_cnt    <= '0;
      irsp_valid  <= 1'b0;
      irsp_error  <= 1'b0;
      irsp_inst   <= '0;
      drsp_valid  <= 1'b0;
      drsp_error  <= 1'b0;
      drsp_data   <= '0;
      dbg_mem_rdy <= 1'b0;
      dbg_di      <= '0;
      mem_op      <= 1'b0;
      mem_adr     <= '0;
      mem_di      <= '0;
      mem_wren    <= '0;
    end else begin
      mem_op      <= 1'b0;
      mem_wren    <= '0;
      irsp_valid  <= 1'b0;
      irsp_error  <= 1'b0;
      drsp_valid  <= 1'b0;
      drsp_error  <= 1'b0;
      dbg_mem_rdy <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gnt_any) begin
            owner     <= sel_own;
            is_read   <= sel_read;
            err       <= sel_err;
            rdata_vld <= 1'b0;
            // Unmapped accesses never reach the bus; the bus regs keep their last value.
            if (!sel_err) begin
              mem_op   <= 1'b1;
              mem_adr  <= sel_adr;
              mem_di   <= sel_dat;
              mem_wren <= sel_wren;
            end
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= (WAIT_CYC == 0) ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= S_RESP;
          else                       wait_cnt <= wait_cnt + 1'b1;
        end
        S_RESP: begin
          if (!rdata_vld) begin
            rdata     <= resp_word;
            rdata_vld <= 1'b1;
          end
          if (owner == OWN_DBG || cpu_en) begin
            if (owner == OWN_DBG) begin
              dbg_mem_rdy <= 1'b1;
              if (is_read) dbg_di <= resp_word;
            end else if (owner == OWN_D) begin
              if (is_read) begin
                drsp_valid <= 1'b1;
                drsp_error <= err;
                drsp_data  <= resp_word;
              end
            end else begin
              irsp_valid <= 1'b1;
              irsp_error <= err;
              irsp_inst  <= resp_word;
            end
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
module tb_cpu_bus_arbiter;

  localparam int L1 = 1;
  localparam int NONE = 0, OI = 1, OD = 2, ODBG = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_reset, n_reset3, cpu_en, zero;
  logic        icmd_valid, icmd_valid3, dcmd_valid, dcmd_wr, dbg_mem_op, dbg_rw;
  logic [31:0] icmd_adr, dcmd_adr, dcmd_data, dbg_adr, dbg_do, mem_do, mem_do3;
  logic [3:0]  dcmd_mask;

  logic        icmd_ready, irsp_valid, irsp_error, dcmd_ready, drsp_valid, drsp_error;
  logic        dbg_mem_rdy, mem_op;
  logic [31:0] irsp_inst, drsp_data, dbg_di, mem_adr, mem_di;
  logic [3:0]  mem_wren;

  logic        icmd_ready3, irsp_valid3, irsp_error3, dcmd_ready3, drsp_valid3, drsp_error3;
  logic        dbg_mem_rdy3, mem_op3;
  logic [31:0] irsp_inst3, drsp_data3, dbg_di3, mem_adr3, mem_di3;
  logic [3:0]  mem_wren3;

  cpu_bus_arbiter #(.RD_LATENCY(1)) u_dut (
    .clk(clk), .n_reset(n_reset), .cpu_en(cpu_en),
    .icmd_valid(icmd_valid), .icmd_ready(icmd_ready), .icmd_adr(icmd_adr),
    .irsp_valid(irsp_valid), .irsp_error(irsp_error), .irsp_inst(irsp_inst),
    .dcmd_valid(dcmd_valid), .dcmd_ready(dcmd_ready), .dcmd_wr(dcmd_wr), .dcmd_mask(dcmd_mask),
    .dcmd_adr(dcmd_adr), .dcmd_data(dcmd_data),
    .drsp_valid(drsp_valid), .drsp_error(drsp_error), .drsp_data(drsp_data),
    .dbg_mem_op(dbg_mem_op), .dbg_rw(dbg_rw), .dbg_adr(dbg_adr), .dbg_do(dbg_do),
    .dbg_mem_rdy(dbg_mem_rdy), .dbg_di(dbg_di),
    .mem_op(mem_op), .mem_adr(mem_adr), .mem_di(mem_di), .mem_wren(mem_wren), .mem_do(mem_do)
  );

  cpu_bus_arbiter #(.RD_LATENCY(3)) u_dut3 (
    .clk(clk), .n_reset(n_reset3), .cpu_en(cpu_en),
    .icmd_valid(icmd_valid3), .icmd_ready(icmd_ready3), .icmd_adr(icmd_adr),
    .irsp_valid(irsp_valid3), .irsp_error(irsp_error3), .irsp_inst(irsp_inst3),
    .dcmd_valid(zero), .dcmd_ready(dcmd_ready3), .dcmd_wr(dcmd_wr), .dcmd_mask(dcmd_mask),
    .dcmd_adr(dcmd_adr), .dcmd_data(dcmd_data),
    .drsp_valid(drsp_valid3), .drsp_error(drsp_error3), .drsp_data(drsp_data3),
    .dbg_mem_op(zero), .dbg_rw(dbg_rw), .dbg_adr(dbg_adr), .dbg_do(dbg_do),
    .dbg_mem_rdy(dbg_mem_rdy3), .dbg_di(dbg_di3),
    .mem_op(mem_op3), .mem_adr(mem_adr3), .mem_di(mem_di3), .mem_wren(mem_wren3), .mem_do(mem_do3)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus contents: one pinned word, everything else derived from the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'hC0DE_0000);
  endfunction

  // Bus slaves: read data RD_LATENCY cycles after the strobe, zero otherwise (OR-bus).
  initial begin : slave
    bit          h1;
    logic [31:0] a1;
    bit          h3 [0:2];
    logic [31:0] a3 [0:2];
    mem_do = '0; mem_do3 = '0; h1 = 0; a1 = '0;
    for (int i = 0; i < 3; i++) begin h3[i] = 0; a3[i] = '0; end
    forever begin
      @(negedge clk);
      h1 = mem_op; a1 = mem_adr;
      for (int i = 2; i > 0; i--) begin h3[i] = h3[i-1]; a3[i] = a3[i-1]; end
      h3[0] = mem_op3; a3[0] = mem_adr3;
      @(posedge clk); #1;
      mem_do  = h1 ? mem_word(a1) : 32'h0;
      mem_do3 = h3[2] ? mem_word(a3[2]) : 32'h0;
    end
  end

  // Transaction-timeline model of the RD_LATENCY=1 instance, checked every cycle.
  int          m_k, m_tg, m_own;
  bit          m_busy, m_err, m_read;
  logic [31:0] m_adr, m_dat, p_word;
  logic [3:0]  m_wren;
  bit          p_i, p_d, p_dbg, p_dbg_rd, p_err;

  initial begin : model
    int own;
    bit exp_op, n_i, n_d, n_dbg;
    m_k = 0; m_busy = 0; m_tg = 0; m_own = NONE; m_err = 0; m_read = 0;
    m_adr = '0; m_dat = '0; m_wren = '0; p_word = '0;
    p_i = 0; p_d = 0; p_dbg = 0; p_dbg_rd = 0; p_err = 0;
    wait (n_reset === 1'b1);
    forever begin
      @(negedge clk);
      chk("irsp_valid", irsp_valid, p_i);
      if (p_i) begin chk("irsp_inst", irsp_inst, p_word); chk("irsp_error", irsp_error, p_err); end
      chk("drsp_valid", drsp_valid, p_d);
      if (p_d) begin chk("drsp_data", drsp_data, p_word); chk("drsp_error", drsp_error, p_err); end
      chk("dbg_mem_rdy", dbg_mem_rdy, p_dbg);
      if (p_dbg && p_dbg_rd) chk("dbg_di", dbg_di, p_word);

      exp_op = m_busy && (m_k == m_tg + 1) && !m_err;
      chk("mem_op", mem_op, exp_op);
      chk("mem_wren", mem_wren, exp_op ? m_wren : 4'h0);
      if (exp_op) chk("mem_adr", mem_adr, m_adr);
      if (exp_op && m_wren != 4'h0) chk("mem_di", mem_di, m_dat);

      own = NONE;
      if (!m_busy) begin
        if (dbg_mem_op && !p_dbg)      own = ODBG;
        else if (dcmd_valid && cpu_en) own = OD;
        else if (icmd_valid && cpu_en) own = OI;
      end
      chk("icmd_ready", icmd_ready, own == OI);
      chk("dcmd_ready", dcmd_ready, own == OD);
      if (own != NONE) begin
        m_busy = 1; m_tg = m_k; m_own = own;
        if (own == ODBG) begin
          m_adr = dbg_adr; m_dat = dbg_do; m_read = dbg_rw; m_wren = dbg_rw ? 4'h0 : 4'hF;
        end else if (own == OD) begin
          m_adr = dcmd_adr; m_dat = dcmd_data; m_read = !dcmd_wr; m_wren = dcmd_wr ? dcmd_mask : 4'h0;
        end else begin
          m_adr = icmd_adr; m_dat = '0; m_read = 1; m_wren = 4'h0;
        end
        m_err = (m_adr >= 32'h0003_0000);
      end

      n_i = 0; n_d = 0; n_dbg = 0;
      if (m_busy && m_k >= m_tg + L1 + 1 && (m_own == ODBG || cpu_en)) begin
        n_i = (m_own == OI); n_d = (m_own == OD) && m_read; n_dbg = (m_own == ODBG);
        p_dbg_rd = m_read; p_err = m_err; p_word = m_err ? 32'h0 : mem_word(m_adr);
        m_busy = 0;
      end
      p_i = n_i; p_d = n_d; p_dbg = n_dbg;
      m_k++;
    end
  end

  // Event log of the current directed test (cycle numbers relative to its start).
  int          rel, t_iacc, t_dacc, t_irsp, t_drsp, t_dbg, n_op, n_irsp, n_drsp, n_dbg;
  int          t_iacc3, t_irsp3, n_irsp3, n_op3;
  int          op_t [$];
  logic [31:0] op_adr [$];
  logic [31:0] op_di [$];
  logic [3:0]  op_wren [$];
  logic [31:0] v_inst, v_ddata, v_dbgdi, v_inst3;
  logic        v_ierr, v_derr;

  task automatic clear_log();
    rel = -1; t_iacc = -1; t_dacc = -1; t_irsp = -1; t_drsp = -1; t_dbg = -1;
    n_op = 0; n_irsp = 0; n_drsp = 0; n_dbg = 0;
    t_iacc3 = -1; t_irsp3 = -1; n_irsp3 = 0; n_op3 = 0;
    op_t.delete(); op_adr.delete(); op_di.delete(); op_wren.delete();
    v_inst = '0; v_ddata = '0; v_dbgdi = '0; v_inst3 = '0; v_ierr = 0; v_derr = 0;
  endtask

  // Advance n cycles; masters drop their request after it is accepted/completed.
  task automatic run(input int n);
    bit ci, cd, cdbg, ci3;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rel++;
      ci = icmd_valid && icmd_ready; cd = dcmd_valid && dcmd_ready;
      cdbg = dbg_mem_rdy; ci3 = icmd_valid3 && icmd_ready3;
      if (ci) t_iacc = rel;
      if (cd) t_dacc = rel;
      if (ci3) t_iacc3 = rel;
      if (mem_op) begin
        n_op++; op_t.push_back(rel); op_adr.push_back(mem_adr);
        op_di.push_back(mem_di); op_wren.push_back(mem_wren);
      end
      if (irsp_valid) begin n_irsp++; t_irsp = rel; v_inst = irsp_inst; v_ierr = irsp_error; end
      if (drsp_valid) begin n_drsp++; t_drsp = rel; v_ddata = drsp_data; v_derr = drsp_error; end
      if (dbg_mem_rdy) begin n_dbg++; t_dbg = rel; v_dbgdi = dbg_di; end
      if (mem_op3) n_op3++;
      if (irsp_valid3) begin n_irsp3++; t_irsp3 = rel; v_inst3 = irsp_inst3; end
      @(posedge clk); #1;
      if (ci) icmd_valid = 0;
      if (cd) dcmd_valid = 0;
      if (cdbg) dbg_mem_op = 0;
      if (ci3) icmd_valid3 = 0;
    end
  endtask

  initial begin : stim
    n_reset = 0; n_reset3 = 0; cpu_en = 1; zero = 0;
    icmd_valid = 0; icmd_valid3 = 0; dcmd_valid = 0; dcmd_wr = 0; dbg_mem_op = 0; dbg_rw = 0;
    icmd_adr = '0; dcmd_adr = '0; dcmd_data = '0; dbg_adr = '0; dbg_do = '0; dcmd_mask = '0;
    clear_log();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_irsp_valid", irsp_valid, 0); chk("rst_drsp_valid", drsp_valid, 0);
    chk("rst_dbg_mem_rdy", dbg_mem_rdy, 0); chk("rst_mem_op", mem_op, 0);
    chk("rst_mem_adr", mem_adr, 0); chk("rst_mem_di", mem_di, 0);
    chk("rst_mem_wren", mem_wren, 0); chk("rst_irsp_inst", irsp_inst, 0);
    chk("rst_dbg_di", dbg_di, 0); chk("rst_mem_op3", mem_op3, 0);
    @(posedge clk); #1;
    n_reset = 1; n_reset3 = 1;

    // iBus fetch from RAM
    clear_log(); icmd_adr = 32'h10; icmd_valid = 1; run(6);
    chk("t1_accept", t_iacc, 0); chk("t1_memop_cycle", op_t.size() > 0 ? op_t[0] : -1, 1);
    chk("t1_rsp_cycle", t_irsp, 3); chk("t1_inst", v_inst, 32'hDEADBEEF);
    chk("t1_rsp_count", n_irsp, 1); chk("t1_err", v_ierr, 0);

    // dBus byte write to MMIO
    clear_log(); dcmd_adr = 32'h0001_0004; dcmd_wr = 1; dcmd_mask = 4'b0011;
    dcmd_data = 32'h1234; dcmd_valid = 1; run(6);
    chk("t2_op_count", n_op, 1); chk("t2_wren", n_op > 0 ? op_wren[0] : 4'hx, 4'b0011);
    chk("t2_adr", n_op > 0 ? op_adr[0] : 32'hx, 32'h0001_0004);
    chk("t2_di", n_op > 0 ? op_di[0] : 32'hx, 32'h1234); chk("t2_no_drsp", n_drsp, 0);

    // Three masters in the same cycle
    clear_log(); dbg_rw = 1; dbg_adr = 32'h20; dbg_mem_op = 1;
    dcmd_wr = 0; dcmd_adr = 32'h0001_0008; dcmd_valid = 1;
    icmd_adr = 32'h0002_0000; icmd_valid = 1; run(14);
    chk("t3_op_count", n_op, 3);
    if (n_op == 3) begin
      chk("t3_first", op_adr[0], 32'h20); chk("t3_second", op_adr[1], 32'h0001_0008);
      chk("t3_third", op_adr[2], 32'h0002_0000); chk("t3_third_cycle", op_t[2], 7);
    end
    chk("t3_dbg_cycle", t_dbg, 3); chk("t3_drsp_cycle", t_drsp, 6); chk("t3_irsp_cycle", t_irsp, 9);
    chk("t3_dbg_di", v_dbgdi, 32'hC0DE_0020); chk("t3_drsp_data", v_ddata, 32'hC0DF_0008);
    chk("t3_irsp_inst", v_inst, 32'hC0DC_0000);
    chk("t3_counts", {n_dbg[7:0], n_drsp[7:0], n_irsp[7:0]}, 32'h010101);

    // Unmapped accesses answered locally
    clear_log(); dcmd_wr = 0; dcmd_adr = 32'h0003_0000; dcmd_valid = 1; run(6);
    chk("t4_no_op", n_op, 0); chk("t4_drsp_count", n_drsp, 1); chk("t4_drsp_cycle", t_drsp, 3);
    chk("t4_drsp_err", v_derr, 1); chk("t4_drsp_data", v_ddata, 0);
    clear_log(); icmd_adr = 32'h0004_0000; icmd_valid = 1; run(6);
    chk("t4b_no_op", n_op, 0); chk("t4b_irsp_err", v_ierr, 1); chk("t4b_irsp_inst", v_inst, 0);

    // cpu_en dropped during ISSUE; debug request must wait
    clear_log(); icmd_adr = 32'h14; icmd_valid = 1; run(1);
    cpu_en = 0; dbg_rw = 0; dbg_adr = 32'h30; dbg_do = 32'hCAFE_F00D; dbg_mem_op = 1; run(5);
    chk("t5_withheld", n_irsp, 0); chk("t5_dbg_blocked", n_op, 1);
    cpu_en = 1; run(8);
    chk("t5_rsp_cycle", t_irsp, 7); chk("t5_rsp_count", n_irsp, 1);
    chk("t5_inst", v_inst, 32'hC0DE_0014); chk("t5_op_count", n_op, 2);
    if (n_op == 2) begin
      chk("t5_dbg_op_cycle", op_t[1], 8); chk("t5_dbg_adr", op_adr[1], 32'h30);
      chk("t5_dbg_wren", op_wren[1], 4'hF); chk("t5_dbg_di", op_di[1], 32'hCAFE_F00D);
    end
    chk("t5_dbg_rdy_cycle", t_dbg, 10);

    // RD_LATENCY=3 instance: normal read, reset mid-WAIT, read again
    clear_log(); icmd_adr = 32'h18; icmd_valid3 = 1; run(8);
    chk("t6_accept", t_iacc3, 0); chk("t6_rsp_cycle", t_irsp3, 5);
    chk("t6_inst", v_inst3, 32'hC0DE_0018); chk("t6_op_count", n_op3, 1);
    clear_log(); icmd_adr = 32'h1C; icmd_valid3 = 1; run(3);
    #2 n_reset3 = 0;
    #1;
    chk("t6_rst_irsp_valid", irsp_valid3, 0); chk("t6_rst_irsp_inst", irsp_inst3, 0);
    chk("t6_rst_mem_adr", mem_adr3, 0); chk("t6_rst_mem_op", mem_op3, 0);
    chk("t6_rst_mem_wren", mem_wren3, 0); chk("t6_rst_icmd_ready", icmd_ready3, 0);
    chk("t6_rst_dbg_rdy", dbg_mem_rdy3, 0); chk("t6_rst_drsp", drsp_valid3, 0);
    @(posedge clk); #1;
    n_reset3 = 1;
    clear_log(); run(6);
    chk("t6_aborted_no_rsp", n_irsp3, 0); chk("t6_aborted_no_op", n_op3, 0);
    clear_log(); icmd_adr = 32'h18; icmd_valid3 = 1; run(8);
    chk("t6_again_cycle", t_irsp3, 5); chk("t6_again_inst", v_inst3, 32'hC0DE_0018);
    chk("t6_again_count", n_irsp3, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
